uart_rx_os16: RTL

//   8N1 UART receiver with 16x oversampling and 3-sample majority vote per bit.

---
 rtl/uart_rx_os16.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and a 3-sample majority vote per bit.
// Each good byte is delivered as a one-cycle rx_vld strobe with rx_data held until the next one.
module uart_rx_os16 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_vld,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic          start_det;
    logic [3:0]    s_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    smp;
    logic [7:0]    shift;
    logic          vote;

    // NOTE: the synchronizer resets to the idle-high line level so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign start_det = (state == IDLE) && !rx_s;
    assign tick      = (div_cnt == DIV_LAST);

    // Restarting the prescaler on the start edge puts sample 8 near each bit centre.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Samples 7 and 8 are stored; sample 9 is the live synchronized input at decision time.
    assign vote = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            s_cnt        <= '0;
            bit_idx      <= '0;
            smp          <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_vld       <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle and are raised only on the deciding edge.
            rx_vld       <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                        s_cnt   <= '0;
                        bit_idx <= '0;
                    end
                end
                default: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 1'b1;
                        if (s_cnt == 4'd7) smp[0] <= rx_s;
                        if (s_cnt == 4'd8) smp[1] <= rx_s;
                        case (state)
                            START: begin
                                if (s_cnt == 4'd9 && vote) begin
                                    state   <= IDLE;
                                    rx_busy <= 1'b0;
                                end else if (s_cnt == 4'd15) begin
                                    state <= DATA;
                                end
                            end
                            DATA: begin
                                if (s_cnt == 4'd9) begin
                                    shift <= {vote, shift[7:1]};
                                end else if (s_cnt == 4'd15) begin
                                    if (bit_idx == 3'd7) state <= STOP;
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end
                            STOP: begin
                                // Leaving at mid-stop leaves half a bit of margin for the next start edge.
                                if (s_cnt == 4'd9) begin
                                    state   <= IDLE;
                                    rx_busy <= 1'b0;
                                    if (vote) begin
                                        rx_data <= shift;
                                        rx_vld  <= 1'b1;
                                    end else begin
                                        rx_frame_err <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
